// File: rtl/register_bank_pkg.sv
// Shared types and default sizing for the register bank.
package register_bank_pkg;

  // Default geometry of the bank.
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 5;
  localparam int unsigned DefRegCount  = 32;
  localparam int unsigned DefReadPorts = 2;

  // Bank controller states; the two spare codes fall back to StClear.
  typedef enum logic [1:0] {
    StClear = 2'b00,
    StReady = 2'b01
  } bank_state_e;

endpackage

// File: rtl/register_bank.sv
// Multi-read-port register bank with a self-clearing start-up sequence.
// Entry 0 is hard-wired to zero. Optional same-cycle write-through on reads
// is enabled by defining REGISTER_BANK_BYPASS_EN.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int unsigned Data_width    = DefDataWidth,
  parameter int unsigned Address_width = DefAddrWidth,
  parameter int unsigned reg_count     = DefRegCount,
  parameter int unsigned read_ports    = DefReadPorts
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr_req,
  input  logic                              write_en,
  input  logic [Address_width-1:0]          DataWrite_addr,
  input  logic [Data_width-1:0]             Write_data,
  input  logic [read_ports*Address_width-1:0] rd_addr,
  output logic [read_ports*Data_width-1:0]  rd_data,
  output logic                              ready,
  output logic                              wr_dropped
);

  localparam logic [Address_width-1:0] LastIdx   = Address_width'(reg_count - 1);
  localparam logic [Address_width:0]   RegCountW = (Address_width + 1)'(reg_count);

  bank_state_e               state_q, state_d;
  logic [Address_width-1:0]  clr_idx_q, clr_idx_d;
  logic                      wr_dropped_q, wr_dropped_d;
  logic [Data_width-1:0]     mem_q [reg_count];

  logic bank_ready;
  logic wr_addr_ok;
  logic wr_accept;

  assign bank_ready = (state_q == StReady);
  assign wr_addr_ok = ({1'b0, DataWrite_addr} < RegCountW);
  // Address 0 writes are swallowed silently; clr_req takes priority over a write.
  assign wr_accept  = bank_ready && write_en && !clr_req && wr_addr_ok &&
                      (DataWrite_addr != '0);

  assign ready      = bank_ready;
  assign wr_dropped = wr_dropped_q;

  // Next-state logic for the clear sequencer and the drop flag.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      StClear: begin
        clr_idx_d = clr_idx_q + Address_width'(1);
        if (clr_idx_q == LastIdx) begin
          state_d   = StReady;
          clr_idx_d = '0;
        end
      end
      StReady: begin
        if (clr_req) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = StClear;
        clr_idx_d = '0;
      end
    endcase
    // A concurrent clr_req hides a bad write address: no drop is flagged then.
    wr_dropped_d = write_en && (!bank_ready || (!clr_req && !wr_addr_ok));
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StClear;
      clr_idx_q    <= '0;
      wr_dropped_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      wr_dropped_q <= wr_dropped_d;
    end
  end

  // Storage array: cleared one entry per cycle in StClear, written when ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StClear) begin
        mem_q[clr_idx_q] <= '0;
      end else if (wr_accept) begin
        mem_q[DataWrite_addr] <= Write_data;
      end
    end
  end

  // One combinational read lane per port.
  for (genvar g = 0; g < read_ports; g++) begin : gen_rd
    logic [Address_width-1:0] lane_addr;
    logic [Data_width-1:0]    lane_data;

    assign lane_addr = rd_addr[g*Address_width +: Address_width];

    // Zero when not ready, for entry 0, or for out-of-range addresses.
    always_comb begin
      lane_data = '0;
      if (bank_ready && (lane_addr != '0) && ({1'b0, lane_addr} < RegCountW)) begin
`ifdef REGISTER_BANK_BYPASS_EN
        if (wr_accept && (lane_addr == DataWrite_addr)) begin
          lane_data = Write_data;
        end else begin
          lane_data = mem_q[lane_addr];
        end
`else
        lane_data = mem_q[lane_addr];
`endif
      end
    end

    assign rd_data[g*Data_width +: Data_width] = lane_data;
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter Data_width, default 32, data bits per entry.
REQ-002 Parameter Address_width, default 5, address bits per port.
REQ-003 Parameter reg_count, default 32, number of entries (2..2**Address_width).
REQ-004 Parameter read_ports, default 2, number of independent read ports (1..4).
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port clr_req  input  1  single-cycle request to re-run the clear sequence.
REQ-008 Port write_en  input  1  write strobe.
REQ-009 Port DataWrite_addr  input  Address_width  write address.
REQ-010 Port Write_data  input  Data_width  write data.
REQ-011 Port rd_addr  input  read_ports x Address_width  read addresses, packed.
REQ-012 Port rd_data  output  read_ports x Data_width  read data, packed.
REQ-013 Port ready  output  1  high when the bank accepts writes and returns stored data.
REQ-014 Port wr_dropped  output  1  registered one-cycle pulse flagging a rejected write.

Function
REQ-015 FSM states: CLEAR and READY only; a 2-bit encoding is allowed, and unused codes SHALL go to CLEAR.
REQ-016 In CLEAR, each rising edge with rst low SHALL zero entry clr_idx and increment clr_idx, so exactly one entry is cleared per cycle.
REQ-017 The edge that clears entry reg_count-1 SHALL move the FSM to READY and set ready high, reg_count edges after rst deasserts.
REQ-018 In READY, clr_req high SHALL move the FSM to CLEAR with clr_idx=0 and drop ready on the next edge.
REQ-019 clr_req in CLEAR SHALL be ignored and SHALL NOT restart clr_idx.
REQ-020 In READY, write_en high with DataWrite_addr in 1..reg_count-1 SHALL store Write_data on the rising edge.
REQ-021 Entry 0 SHALL always read 0; a write to address 0 SHALL be discarded silently with no wr_dropped.
REQ-022 Read data SHALL be combinational from rd_addr with zero latency.
REQ-023 While ready is low, every rd_data lane SHALL read 0.
REQ-024 A read address >= reg_count SHALL return 0.
REQ-025 A write while ready is low, or to an address >= reg_count, SHALL be discarded and SHALL pulse wr_dropped on the next cycle.
REQ-026 clr_req and write_en together in READY: the write is discarded, and wr_dropped SHALL NOT pulse.

Reset
REQ-027 rst high SHALL force state CLEAR, clr_idx=0, ready=0 and wr_dropped=0, including mid-clear, where it restarts the sequence at entry 0.
REQ-028 Entry contents need no direct reset; the clear sequence initialises every entry.

Configuration
REQ-029 Macro REGISTER_BANK_BYPASS_EN defined: in READY, a read whose address equals a valid, accepted write address in the same cycle SHALL return Write_data (write-through), except address 0, which returns 0.
REQ-030 Macro undefined: the same-cycle read SHALL return the old stored value, and the new value is visible from the next cycle.

Structure
REQ-031 Package register_bank_pkg SHALL hold the FSM state enum and the default width, depth and port-count constants.
REQ-032 The bank SHALL be built as one module with no sub-module; the read lanes SHALL be produced by a generate loop over read_ports.

Verification
REQ-033 rst high 2 cycles, then low -> ready=0 for 32 edges and high after the 32nd; all lanes read 0 throughout.
REQ-034 In READY, write 0xDEADBEEF to address 5, then read address 5 on lane 0 and address 0 on lane 1 -> 0xDEADBEEF and 0.
REQ-035 Same-cycle write 0x12345678 to address 9 with read of address 9 -> 0x12345678 with the macro defined, previous value without it.
REQ-036 write_en to address 3 during CLEAR -> write ignored, wr_dropped=1 for exactly one cycle, and address 3 reads 0 after ready.
REQ-037 Fill all entries with their index, pulse clr_req -> ready low 32 cycles, then every entry reads 0.
REQ-038 Assert rst at clr_idx=17 -> after release, ready rises exactly 32 edges later.
